// File: rtl/dcache_responder_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
package dcache_responder_pkg;

   localparam int DCACHE_OFFSET_W = 5;
   localparam int DCACHE_LINE_W   = 256;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      ALLOCATE
   } dcache_state_t;

   // Places a 4-bit word mask onto the 32 byte lanes of a line.
   function automatic logic [31:0] word_byte_en(input logic [2:0] word, input logic [3:0] mask);
      return {28'd0, mask} << {word, 2'b00};
   endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// Requester (dmem) and line-wide backing-memory (dfp) signals of the data cache.
interface dcache_responder_if;
   import dcache_responder_pkg::*;

   logic [31:0]              dmem_address;
   logic                     dmem_read;
   logic                     dmem_write;
   logic [3:0]               dmem_wmask;
   logic [31:0]              dmem_wdata;
   logic [31:0]              dmem_rdata;
   logic                     dmem_resp;

   logic [31:0]              dfp_address;
   logic                     dfp_read;
   logic                     dfp_write;
   logic [DCACHE_LINE_W-1:0] dfp_wdata;
   logic [DCACHE_LINE_W-1:0] dfp_rdata;
   logic                     dfp_resp;

   modport slave (
      input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
      output dmem_rdata, dmem_resp,
      output dfp_address, dfp_read, dfp_write, dfp_wdata,
      input  dfp_rdata, dfp_resp
   );

   modport master (
      output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
      input  dmem_rdata, dmem_resp,
      input  dfp_address, dfp_read, dfp_write, dfp_wdata,
      output dfp_rdata, dfp_resp
   );

endinterface

// File: rtl/dcache_line_array.sv
// SETS x 256-bit line storage: combinational read, per-byte write, full-line fill.
module dcache_line_array
   import dcache_responder_pkg::*;
#(
   parameter int SETS = 16,
   localparam int IDX_W = $clog2(SETS)
) (
   input  logic                       clk,
   input  logic [IDX_W-1:0]           idx,
   input  logic                       fill,
   input  logic [DCACHE_LINE_W/8-1:0] byte_en,
   input  logic [DCACHE_LINE_W-1:0]   wdata,
   output logic [DCACHE_LINE_W-1:0]   rdata
);

   logic [DCACHE_LINE_W-1:0] lines [SETS];

   always_ff @(posedge clk) begin
      if (fill) begin
         lines[idx] <= wdata;
      end else begin
         for (int b = 0; b < DCACHE_LINE_W/8; b++) begin
            if (byte_en[b]) lines[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata = lines[idx];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache behind the dmem port.
// DCACHE_PERF_CNT_EN enables the hit/miss counters; otherwise both count ports read zero.
module dcache_responder
   import dcache_responder_pkg::*;
#(
   parameter int SETS = 16
) (
   input  logic               clk,
   input  logic               rst,
   dcache_responder_if.slave  bus,
   output logic [31:0]        hit_count,
   output logic [31:0]        miss_count
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - DCACHE_OFFSET_W - IDX_W;

   dcache_state_t            state, state_next;
   logic [31:2]              req_addr;
   logic                     req_write;
   logic [3:0]               req_wmask;
   logic [31:0]              req_wdata;
   logic [SETS-1:0]          valid, dirty;
   logic [TAG_W-1:0]         tags [SETS];
   logic [31:0]              rdata_q;

   logic [IDX_W-1:0]         idx;
   logic [TAG_W-1:0]         req_tag;
   logic [2:0]               word;
   logic [DCACHE_LINE_W-1:0] line;
   logic [31:0]              line_word;
   logic [31:0]              byte_en;
   logic                     hit, fill;
   logic                     unused_addr_bits;

   assign unused_addr_bits = ^bus.dmem_address[1:0];

   assign idx       = req_addr[DCACHE_OFFSET_W +: IDX_W];
   assign req_tag   = req_addr[31 -: TAG_W];
   assign word      = req_addr[4:2];
   assign hit       = valid[idx] && (tags[idx] == req_tag);
   assign line_word = line[{word, 5'b0} +: 32];

   dcache_line_array #(.SETS(SETS)) u_lines (
      .clk     (clk),
      .idx     (idx),
      .fill    (fill),
      .byte_en (byte_en),
      .wdata   (fill ? bus.dfp_rdata : {8{req_wdata}}),
      .rdata   (line)
   );

   always_comb begin
      state_next      = state;
      fill            = 1'b0;
      byte_en         = '0;
      bus.dmem_resp   = 1'b0;
      bus.dfp_read    = 1'b0;
      bus.dfp_write   = 1'b0;
      bus.dfp_address = '0;
      bus.dfp_wdata   = '0;
      case (state)
         IDLE: begin
            if (bus.dmem_read || bus.dmem_write) state_next = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               bus.dmem_resp = 1'b1;
               state_next    = IDLE;
               if (req_write) byte_en = word_byte_en(word, req_wmask);
            end else if (valid[idx] && dirty[idx]) begin
               state_next = WRITEBACK;
            end else begin
               state_next = ALLOCATE;
            end
         end
         WRITEBACK: begin
            bus.dfp_write   = 1'b1;
            bus.dfp_address = {tags[idx], idx, 5'b0};
            bus.dfp_wdata   = line;
            if (bus.dfp_resp) state_next = ALLOCATE;
         end
         ALLOCATE: begin
            bus.dfp_read    = 1'b1;
            bus.dfp_address = {req_tag, idx, 5'b0};
            if (bus.dfp_resp) begin
               fill       = 1'b1;
               state_next = COMPARE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Read data stays visible after the response until the next read hit.
   assign bus.dmem_rdata = (state == COMPARE && hit && !req_write) ? line_word : rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         valid   <= '0;
         dirty   <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_next;
         if (state == COMPARE && hit) begin
            if (req_write) dirty[idx] <= 1'b1;
            else           rdata_q    <= line_word;
         end
         if (state == WRITEBACK && bus.dfp_resp) dirty[idx] <= 1'b0;
         if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end
      end
   end

   // A simultaneous read and write is captured as a write.
   always_ff @(posedge clk) begin
      if (state == IDLE && (bus.dmem_read || bus.dmem_write)) begin
         req_addr  <= bus.dmem_address[31:2];
         req_write <= bus.dmem_write;
         req_wmask <= bus.dmem_wmask;
         req_wdata <= bus.dmem_wdata;
      end
      if (fill) tags[idx] <= req_tag;
   end

`ifdef DCACHE_PERF_CNT_EN
   logic        first_eval;
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         first_eval <= 1'b0;
         hit_q      <= '0;
         miss_q     <= '0;
      end else begin
         if (state == IDLE && state_next == COMPARE) first_eval <= 1'b1;
         else if (state == COMPARE)                  first_eval <= 1'b0;
         if (state == COMPARE && first_eval) begin
            if (hit) hit_q  <= hit_q + 32'd1;
            else     miss_q <= miss_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

`ifndef SYNTHESIS
   rw_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(state == IDLE && bus.dmem_read && bus.dmem_write))
      else $error("dcache_responder: read and write requested together");
`endif

endmodule
